mem_link_ctrl: RTL and testbench
================================

MEM_LINK_CTRL -- requirements
Module: mem_link_ctrl

Interface
REQ-001 SHALL have ports: CLK in 1 system clock; RST in 1 reset, synchronous, active-high.
REQ-002 SHALL accept core-side fetch inputs: iREN in 1 fetch request; iaddr in 32 fetch word address.
REQ-003 SHALL accept core-side data inputs: dREN in 1 load; dWEN in 1 store; datomic in 1 LL/SC qualifier; daddr in 32; dstore in 32 store data.
REQ-004 SHALL drive core-side outputs: ihit out 1; iload out 32; dhit out 1; dload out 32.
REQ-005 SHALL drive RAM outputs: ramREN out 1; ramWEN out 1; ramaddr out 32; ramstore out 32.
REQ-006 SHALL accept RAM inputs: ramload in 32; ram_ack in 1, one-cycle completion of the current access.
REQ-007 SHALL accept snoop inputs: snoop_valid in 1 foreign write seen; snoop_addr in 32.
REQ-008 SHALL use one clock with synchronous, active-high reset; no other clock domains.

Function
REQ-009 SHALL implement states IDLE, DREQ, IREQ, SCFAIL, all registered.
REQ-010 IDLE SHALL sample requests; data (dREN|dWEN) has priority over iREN; no requests -> stay IDLE.
REQ-011 IDLE with dWEN&datomic and link miss SHALL go to SCFAIL, no RAM access.
REQ-012 IDLE with other data request SHALL go to DREQ; with only iREN SHALL go to IREQ.
REQ-013 DREQ SHALL drive ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore combinationally until ram_ack.
REQ-014 IREQ SHALL drive ramREN=1, ramWEN=0, ramaddr=iaddr until ram_ack.
REQ-015 On ram_ack in DREQ: dhit=1 that cycle; dload=ramload for loads/LL, 32'd1 for successful SC, 32'd0 for plain SW; next state IDLE.
REQ-016 On ram_ack in IREQ: ihit=1, iload=ramload that cycle; next state IDLE.
REQ-017 SCFAIL SHALL assert dhit=1, dload=32'd0 for exactly one cycle, then IDLE.
REQ-018 Minimum latency: request in IDLE cycle N, hit at N+1 (ack in first DREQ/IREQ cycle) or N+1 for SCFAIL.
REQ-019 ram_ack in IDLE or SCFAIL SHALL be ignored.
REQ-020 Core SHALL hold request and address stable until hit; controller need not re-check them mid-access.
REQ-021 Link register: linkaddr[31:2], linkvalid; compare uses bits [31:2] only.
REQ-022 LL completion (ram_ack, dREN&datomic) SHALL set linkaddr=daddr[31:2], linkvalid=1.
REQ-023 SC link hit SHALL be decided in IDLE; SC completion SHALL clear linkvalid.
REQ-024 Plain SW completion to linkaddr SHALL clear linkvalid.
REQ-025 snoop_valid with snoop_addr[31:2]==linkaddr SHALL clear linkvalid next cycle.
REQ-026 Simultaneous LL completion and snoop to the same address as daddr SHALL leave linkvalid=0.
REQ-027 Snoop during DREQ for a linked SC already accepted SHALL not abort it; SC still succeeds.
REQ-028 ihit and dhit SHALL never be asserted in the same cycle.
REQ-029 ramREN and ramWEN SHALL never both be 1; both 0 outside DREQ/IREQ.

Reset
REQ-030 RST SHALL force state IDLE, linkvalid=0, linkaddr=0 on the next CLK edge, overriding all inputs.
REQ-031 During/after reset: ihit=dhit=0, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-032 RST mid-access SHALL abandon the access; a late ram_ack SHALL produce no hit.

Verification
REQ-033 iREN=1, iaddr=0x40, ack after 3 cycles with ramload=0xDEADBEEF -> ramREN high 3 cycles, ihit=1, iload=0xDEADBEEF in ack cycle.
REQ-034 iREN and dREN together, daddr=0x100 -> DREQ first, dhit, then IREQ; never both hits same cycle.
REQ-035 LL 0x200, then SC 0x200 dstore=5 -> ramWEN=1 ramstore=5, dhit with dload=1, linkvalid=0 after.
REQ-036 LL 0x200, snoop_addr=0x203, then SC 0x200 -> no ramWEN, dhit next cycle, dload=0.
REQ-037 LL 0x200, SW 0x204, SC 0x200 -> SC succeeds (dload=1); repeat with SW 0x200 -> SC fails (dload=0).
REQ-038 RST asserted in DREQ before ack, then ack pulse -> state IDLE, dhit=0, all RAM strobes 0.

Source files
------------

// File: rtl/mem_link_ctrl_if.sv
// Bundle of the core-side, RAM-side and snoop signals of the memory link controller.
// The controller uses the slave view; the core/RAM environment uses the master view.
interface mem_link_ctrl_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic        datomic;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ack;
  logic        snoop_valid;
  logic [31:0] snoop_addr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore,
    input  ramload, ram_ack, snoop_valid, snoop_addr,
    output ihit, iload, dhit, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore,
    output ramload, ram_ack, snoop_valid, snoop_addr,
    input  ihit, iload, dhit, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_link_ctrl.sv
// Single-port memory arbiter between instruction fetch and data access, with an
// LL/SC link register that is invalidated by stores and snooped foreign writes.
module mem_link_ctrl (
  input  logic     CLK,
  input  logic     RST,
  mem_link_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DREQ, IREQ, SCFAIL} state_t;

  state_t      state;
  logic [29:0] linkaddr;
  logic        linkvalid;

  logic data_req;
  logic is_ll;
  logic is_sc;
  logic link_hit;
  logic ack_d;
  logic ll_done;
  logic sc_done;
  logic sw_done;
  logic sw_hits_link;
  logic snoop_hits_link;
  logic snoop_hits_daddr;
  logic unused_addr_bits;

  always_comb begin
    data_req         = bus.dREN | bus.dWEN;
    is_ll            = bus.dREN & ~bus.dWEN & bus.datomic;
    is_sc            = bus.dWEN & bus.datomic;
    link_hit         = linkvalid && (linkaddr == bus.daddr[31:2]);
    ack_d            = (state == DREQ) && bus.ram_ack;
    ll_done          = ack_d & is_ll;
    sc_done          = ack_d & is_sc;
    sw_done          = ack_d & bus.dWEN & ~bus.datomic;
    sw_hits_link     = sw_done && (linkaddr == bus.daddr[31:2]);
    snoop_hits_link  = bus.snoop_valid && (bus.snoop_addr[31:2] == linkaddr);
    snoop_hits_daddr = bus.snoop_valid && (bus.snoop_addr[31:2] == bus.daddr[31:2]);
    unused_addr_bits = ^{bus.daddr[1:0], bus.snoop_addr[1:0]};
  end

  // Outputs are decoded from the registered state; reset forces them quiet even
  // while the state register still holds an abandoned access.
  always_comb begin
    bus.ihit     = 1'b0;
    bus.iload    = 32'd0;
    bus.dhit     = 1'b0;
    bus.dload    = 32'd0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    if (!RST) begin
      unique case (state)
        DREQ: begin
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          bus.ramWEN   = bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          if (bus.ram_ack) begin
            bus.dhit = 1'b1;
            if (bus.dWEN) begin
              bus.dload = bus.datomic ? 32'd1 : 32'd0;
            end else begin
              bus.dload = bus.ramload;
            end
          end
        end
        IREQ: begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (bus.ram_ack) begin
            bus.ihit  = 1'b1;
            bus.iload = bus.ramload;
          end
        end
        SCFAIL: begin
          bus.dhit = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // A failing SC is resolved in IDLE so it never reaches the RAM; an LL that
  // completes alongside a snoop to its own address leaves the link invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      linkaddr  <= 30'd0;
      linkvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req) begin
            state <= (is_sc && !link_hit) ? SCFAIL : DREQ;
          end else if (bus.iREN) begin
            state <= IREQ;
          end
        end
        DREQ:    if (bus.ram_ack) state <= IDLE;
        IREQ:    if (bus.ram_ack) state <= IDLE;
        SCFAIL:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (ll_done) begin
        linkaddr  <= bus.daddr[31:2];
        linkvalid <= ~snoop_hits_daddr;
      end else if (sc_done || sw_hits_link || snoop_hits_link) begin
        linkvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_link_ctrl.sv
// Self-checking bench for mem_link_ctrl: a RAM responder with programmable latency
// and a scoreboard of expected hits that is drained by a negedge monitor.
module tb_mem_link_ctrl;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  mem_link_ctrl_if bus ();

  mem_link_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic        isInstr;
    logic [31:0] value;
  } expect_t;

  expect_t sbQueue[$];
  expect_t sbItem;
  int      testCount = 0;
  int      failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Every hit the DUT raises must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (bus.ihit || bus.dhit) begin
      checkOutput("hit_exclusive", 32'(bus.ihit & bus.dhit), 32'd0);
      checkOutput("sb_nonempty", 32'(sbQueue.size() != 0), 32'd1);
      if (sbQueue.size() != 0) begin
        sbItem = sbQueue.pop_front();
        checkOutput("hit_port", 32'(bus.ihit), 32'(sbItem.isInstr));
        if (sbItem.isInstr) checkOutput("iload", bus.iload, sbItem.value);
        else                checkOutput("dload", bus.dload, sbItem.value);
      end
    end
  end

  task automatic idleInputs();
    bus.iREN        = 1'b0;
    bus.iaddr       = 32'd0;
    bus.dREN        = 1'b0;
    bus.dWEN        = 1'b0;
    bus.datomic     = 1'b0;
    bus.daddr       = 32'd0;
    bus.dstore      = 32'd0;
    bus.ramload     = 32'd0;
    bus.ram_ack     = 1'b0;
    bus.snoop_valid = 1'b0;
    bus.snoop_addr  = 32'd0;
  endtask

  task automatic checkQuiet();
    checkOutput("q_ihit", 32'(bus.ihit), 32'd0);
    checkOutput("q_dhit", 32'(bus.dhit), 32'd0);
    checkOutput("q_iload", bus.iload, 32'd0);
    checkOutput("q_dload", bus.dload, 32'd0);
    checkOutput("q_ramREN", 32'(bus.ramREN), 32'd0);
    checkOutput("q_ramWEN", 32'(bus.ramWEN), 32'd0);
    checkOutput("q_ramaddr", bus.ramaddr, 32'd0);
    checkOutput("q_ramstore", bus.ramstore, 32'd0);
  endtask

  // Acts as the RAM: acks in the lat-th strobe cycle and returns once one hit is seen.
  task automatic waitHit(input int lat, input logic [31:0] rdata, input logic [31:0] expAddr,
                         input logic expWen, input logic [31:0] expStore,
                         output int ramCycles, output int hitCycle);
    int cyc;
    bit done;
    cyc       = 0;
    done      = 1'b0;
    ramCycles = 0;
    hitCycle  = -1;
    while (!done && cyc < 40) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (bus.ramREN || bus.ramWEN) begin
        ramCycles++;
        checkOutput("strobe_exclusive", 32'(bus.ramREN & bus.ramWEN), 32'd0);
        if (ramCycles == 1) begin
          checkOutput("ramaddr", bus.ramaddr, expAddr);
          checkOutput("ramWEN", 32'(bus.ramWEN), 32'(expWen));
          if (expWen) checkOutput("ramstore", bus.ramstore, expStore);
        end
        if (ramCycles >= lat) begin
          bus.ram_ack = 1'b1;
          bus.ramload = rdata;
        end
      end
      #1;
      if (bus.ihit || bus.dhit) begin
        done     = 1'b1;
        hitCycle = cyc;
      end
    end
    checkOutput("hit_within_budget", 32'(done), 32'd1);
    @(posedge CLK);
    #1;
    bus.ram_ack = 1'b0;
  endtask

  // One data access from IDLE; expRamCycles of 0 means the SC must fail locally.
  task automatic applyStimulus(input logic ren, input logic wen, input logic atomic,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int lat, input logic [31:0] rdata,
                               input logic [31:0] expVal, input int expRamCycles);
    int ramCycles;
    int hitCycle;
    bus.dREN    = ren;
    bus.dWEN    = wen;
    bus.datomic = atomic;
    bus.daddr   = addr;
    bus.dstore  = wdata;
    sbQueue.push_back('{isInstr: 1'b0, value: expVal});
    waitHit(lat, rdata, addr, wen, wdata, ramCycles, hitCycle);
    checkOutput("ram_cycles", 32'(ramCycles), 32'(expRamCycles));
    checkOutput("hit_latency", 32'(hitCycle), (expRamCycles == 0) ? 32'd1 : 32'(lat));
    bus.dREN    = 1'b0;
    bus.dWEN    = 1'b0;
    bus.datomic = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] rdata);
    int ramCycles;
    int hitCycle;
    bus.iREN  = 1'b1;
    bus.iaddr = addr;
    sbQueue.push_back('{isInstr: 1'b1, value: rdata});
    waitHit(lat, rdata, addr, 1'b0, 32'd0, ramCycles, hitCycle);
    checkOutput("fetch_ram_cycles", 32'(ramCycles), 32'(lat));
    checkOutput("fetch_latency", 32'(hitCycle), 32'(lat));
    bus.iREN = 1'b0;
  endtask

  task automatic pulseReset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int ramCycles;
    int hitCycle;
    idleInputs();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkQuiet();
    RST = 1'b0;
    @(posedge CLK);
    #1;

    fetch(32'h40, 3, 32'hDEADBEEF);
    fetch(32'h44, 1, 32'h0BADF00D);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h80, 32'd0, 1, 32'h12345678, 32'h12345678, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h84, 32'hCAFE, 2, 32'hFFFFFFFF, 32'd0, 2);

    // Simultaneous data and fetch: data is served first, the fetch follows.
    bus.dREN  = 1'b1;
    bus.daddr = 32'h100;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h48;
    sbQueue.push_back('{isInstr: 1'b0, value: 32'hA5A5A5A5});
    sbQueue.push_back('{isInstr: 1'b1, value: 32'h5A5A5A5A});
    waitHit(2, 32'hA5A5A5A5, 32'h100, 1'b0, 32'd0, ramCycles, hitCycle);
    checkOutput("dual_data_latency", 32'(hitCycle), 32'd2);
    bus.dREN = 1'b0;
    waitHit(1, 32'h5A5A5A5A, 32'h48, 1'b0, 32'd0, ramCycles, hitCycle);
    checkOutput("dual_fetch_latency", 32'(hitCycle), 32'd1);
    bus.iREN = 1'b0;

    // LL then SC succeeds once; the completed SC consumes the link.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 32'd0, 2, 32'h77, 32'h77, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 32'd5, 1, 32'd0, 32'd1, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 32'd6, 1, 32'd0, 32'd0, 0);

    // A snoop to another byte of the linked word breaks the link.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 32'd0, 1, 32'h88, 32'h88, 1);
    bus.snoop_valid = 1'b1;
    bus.snoop_addr  = 32'h203;
    @(posedge CLK);
    #1;
    bus.snoop_valid = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 32'd9, 1, 32'd0, 32'd0, 0);

    // A store to a neighbouring word keeps the link; a store to the word kills it.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 32'd0, 1, 32'h99, 32'h99, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h204, 32'h11, 2, 32'd0, 32'd0, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 32'h22, 1, 32'd0, 32'd1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 32'd0, 1, 32'hAA, 32'hAA, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h200, 32'h33, 1, 32'd0, 32'd0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 32'h44, 1, 32'd0, 32'd0, 0);

    // A snoop arriving with an already-linked SC does not abort it.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 32'd0, 1, 32'hBB, 32'hBB, 1);
    bus.snoop_valid = 1'b1;
    bus.snoop_addr  = 32'h300;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h300, 32'h55, 3, 32'd0, 32'd1, 3);
    bus.snoop_valid = 1'b0;

    // LL completing together with a snoop to its own word leaves no link.
    bus.snoop_valid = 1'b1;
    bus.snoop_addr  = 32'h400;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h400, 32'd0, 2, 32'hCC, 32'hCC, 2);
    bus.snoop_valid = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h400, 32'h66, 1, 32'd0, 32'd0, 0);

    // ram_ack while idle must not create a hit.
    bus.ram_ack = 1'b1;
    bus.ramload = 32'hEEEEEEEE;
    #1;
    checkOutput("idle_ack_dhit", 32'(bus.dhit), 32'd0);
    checkOutput("idle_ack_ihit", 32'(bus.ihit), 32'd0);
    @(posedge CLK);
    #1;
    bus.ram_ack = 1'b0;

    // Reset in the middle of a load abandons it; the late ack is ignored.
    bus.dREN  = 1'b1;
    bus.daddr = 32'h500;
    @(posedge CLK);
    #1;
    checkOutput("dreq_active", 32'(bus.ramREN), 32'd1);
    RST = 1'b1;
    #1;
    checkQuiet();
    @(posedge CLK);
    #1;
    RST         = 1'b0;
    bus.dREN    = 1'b0;
    bus.ram_ack = 1'b1;
    #1;
    checkQuiet();
    @(posedge CLK);
    #1;
    bus.ram_ack = 1'b0;
    #1;
    checkQuiet();

    // Reset also drops an established link.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h600, 32'd0, 1, 32'hDD, 32'hDD, 1);
    pulseReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h600, 32'h77, 1, 32'd0, 32'd0, 0);

    repeat (2) @(posedge CLK);
    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
